// File: rtl/aoc4_top.sv
// aoc4_top: grid-erosion accelerator that repeatedly strips '@' cells with fewer than 4 occupied neighbours.
//   clock, reset (async, active-high)
//   run_in        start pulse, honoured in IDLE only
//   pad_en        host owns the memory port
//   tb_packet_in  {row_addr, col_addr, partial_vec, write_en, read_en, staging}
//   mem_ack_out   one-cycle host access acknowledge
//   mem_busy_out  host access in flight
//   done_out      last run finished
//   updates_out   cells removed in the last run (saturating)
//   passes_out    passes executed, only when AOC4_PASS_COUNT_EN is defined
module aoc4_mem #(
  parameter int ROWS = 140,
  parameter int COLS = 140,
  parameter int AW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [COLS-1:0] wdata,
  input  logic [COLS-1:0] wmask,
  input  logic [AW-1:0]   raddr,
  output logic [COLS-1:0] rdata
);
  if (1) begin : data
    logic [COLS-1:0] mem [ROWS];
    always_ff @(posedge clock or posedge reset)
      if (reset) for (int i = 0; i < ROWS; i++) mem[i] <= '0;
      else if (we) mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
  end
  assign rdata = data.mem[raddr];
endmodule

module aoc4_top #(
  parameter int MAX_COLS = 140,
  parameter int BANK_DEPTH = 140,
  parameter int TX_DATA_WIDTH = 32,
  parameter int BANK_ADDR_WIDTH = $clog2(BANK_DEPTH),
  parameter int COL_ADDR_WIDTH = $clog2(MAX_COLS) + 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run_in,
  input  logic        pad_en,
  input  logic [BANK_ADDR_WIDTH+COL_ADDR_WIDTH+TX_DATA_WIDTH+2:0] tb_packet_in,
  output logic        mem_ack_out,
  output logic        mem_busy_out,
  output logic        done_out,
  output logic [31:0] updates_out
`ifdef AOC4_PASS_COUNT_EN
  , output logic [15:0] passes_out
`endif
);
  localparam logic [BANK_ADDR_WIDTH-1:0] LAST = BANK_ADDR_WIDTH'(BANK_DEPTH - 1);
  typedef enum logic [2:0] {IDLE, HOST_ACK, HOST_END, PASS_START, READ, COMPUTE, WRITEBACK, PASS_END} state_t;
  state_t state, next;
  logic [BANK_ADDR_WIDTH-1:0] p_row, h_row, row, raddr, waddr;
  logic [COL_ADDR_WIDTH-1:0] p_col, col_al;
  logic [TX_DATA_WIDTH-1:0] p_vec;
  logic p_wr, p_rd, unused_staging, h_wr, changed, we;
  logic [MAX_COLS-1:0] h_data, h_mask, prev, cur, nxt, new_row, new_c, rdata, wdata, wmask;
  logic [MAX_COLS+1:0] pp, cp, np;
  logic [31:0] removed;
  logic [32:0] sum;
  logic [3:0] n;
  assign {p_row, p_col, p_vec, p_wr, p_rd, unused_staging} = tb_packet_in;
  // column address is chunk aligned: its low bits never select a position
  assign col_al = p_col & ~COL_ADDR_WIDTH'(TX_DATA_WIDTH - 1);
  assign mem_busy_out = state == HOST_ACK || state == HOST_END;
  assign mem_ack_out = state == HOST_END;
  assign we = (state == HOST_ACK && h_wr && h_row <= LAST) || state == WRITEBACK;
  assign waddr = state == WRITEBACK ? row : h_row;
  assign wdata = state == WRITEBACK ? new_row : h_data;
  assign wmask = state == WRITEBACK ? '1 : h_mask;
  assign raddr = state == READ && row != LAST ? row + BANK_ADDR_WIDTH'(1) : '0;
  assign sum = 33'(updates_out) + 33'(removed);
  aoc4_mem #(.ROWS(BANK_DEPTH), .COLS(MAX_COLS), .AW(BANK_ADDR_WIDTH)) main_mem (
    .clock(clock), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .wmask(wmask), .raddr(raddr), .rdata(rdata)
  );
  // zero-padded window rows so the grid edges see out-of-grid cells as empty
  assign pp = {1'b0, prev, 1'b0};
  assign cp = {1'b0, cur, 1'b0};
  assign np = {1'b0, nxt, 1'b0};
  always_comb begin
    new_c = '0;
    n = '0;
    for (int c = 0; c < MAX_COLS; c++) begin
      n = 4'(pp[c]) + 4'(pp[c+1]) + 4'(pp[c+2]) + 4'(cp[c]) + 4'(cp[c+2]) + 4'(np[c]) + 4'(np[c+1]) + 4'(np[c+2]);
      new_c[c] = cp[c+1] && n >= 4'd4;
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:       next = run_in ? PASS_START : pad_en && (p_wr || p_rd) ? HOST_ACK : IDLE;
      HOST_ACK:   next = HOST_END;
      HOST_END:   next = IDLE;
      PASS_START: next = READ;
      READ:       next = COMPUTE;
      COMPUTE:    next = WRITEBACK;
      WRITEBACK:  next = row == LAST ? PASS_END : READ;
      PASS_END:   next = changed ? PASS_START : IDLE;
      default:    next = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      h_row <= '0;
      h_data <= '0;
      h_mask <= '0;
      h_wr <= 1'b0;
      row <= '0;
      prev <= '0;
      cur <= '0;
      nxt <= '0;
      new_row <= '0;
      removed <= '0;
      changed <= 1'b0;
      updates_out <= '0;
      done_out <= 1'b0;
`ifdef AOC4_PASS_COUNT_EN
      passes_out <= '0;
`endif
    end else begin
      if (state == IDLE && run_in) begin
        updates_out <= '0;
        done_out <= 1'b0;
`ifdef AOC4_PASS_COUNT_EN
        passes_out <= '0;
`endif
      end
      if (state == IDLE) begin
        h_row <= p_row;
        h_data <= MAX_COLS'(p_vec) << col_al;
        h_mask <= MAX_COLS'({TX_DATA_WIDTH{1'b1}}) << col_al;
        h_wr <= p_wr;
      end
      if (state == PASS_START) begin
        row <= '0;
        prev <= '0;
        cur <= rdata;
        changed <= 1'b0;
`ifdef AOC4_PASS_COUNT_EN
        passes_out <= passes_out + 16'(passes_out != '1);
`endif
      end
      if (state == READ) nxt <= row == LAST ? '0 : rdata;
      if (state == COMPUTE) begin
        new_row <= new_c;
        removed <= 32'($countones(cur & ~new_c));
      end
      // the written row becomes prev so later rows see the eroded grid
      if (state == WRITEBACK) begin
        prev <= new_row;
        cur <= nxt;
        row <= row + BANK_ADDR_WIDTH'(1);
        changed <= changed || removed != 0;
        updates_out <= sum[32] ? '1 : sum[31:0];
      end
      if (state == PASS_END && !changed) done_out <= 1'b1;
    end
endmodule

// File: tb/tb_aoc4_top.sv
// tb_aoc4_top: randomized self-checking bench for aoc4_top against a synchronous-pass grid model.
`timescale 1ns/1ps
module tb_aoc4_top;
  localparam int C = 140, R = 140, TX = 32, AW = 8, CW = 9;
  logic clock = 0, reset = 1, run_in = 0, pad_en = 0;
  logic [AW+CW+TX+2:0] tb_packet_in = '0;
  logic mem_ack_out, mem_busy_out, done_out;
  logic [31:0] updates_out;
`ifdef AOC4_PASS_COUNT_EN
  logic [15:0] passes_out;
`endif
  int tests = 0, fails = 0;
  bit [C-1:0] mg [R];
  bit [C-1:0] g0 [R];
  string sample [10] = '{"..@@.@@@@.", "@@@.@.@.@@", "@@@@@.@.@@", "@.@@@@..@.", "@@.@@@@.@@",
                         ".@@@@@@@.@", ".@.@.@.@@@", "@.@@@.@@@@", ".@@@@@@@@.", "@.@.@@@.@."};
  always #5 clock = ~clock;
  aoc4_top dut (
    .clock(clock), .reset(reset), .run_in(run_in), .pad_en(pad_en), .tb_packet_in(tb_packet_in),
    .mem_ack_out(mem_ack_out), .mem_busy_out(mem_busy_out), .done_out(done_out), .updates_out(updates_out)
`ifdef AOC4_PASS_COUNT_EN
    , .passes_out(passes_out)
`endif
  );
  task automatic check(input string tag, input logic [C-1:0] got, input logic [C-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic check_grid(input string tag);
    int bad = 0;
    for (int r = 0; r < R; r++) if (dut.main_mem.data.mem[r] !== mg[r]) bad++;
    check(tag, bad, 0);
  endtask
  task automatic do_reset();
    reset = 1;
    repeat (3) step();
    reset = 0;
    for (int r = 0; r < R; r++) mg[r] = '0;
  endtask
  task automatic host_req(input int row, input int col, input logic [31:0] vec, input bit wr);
    int k;
    tb_packet_in = {AW'(row), CW'(col), vec, wr, !wr, 1'($urandom)};
    pad_en = 1;
    for (k = 0; k < 20 && !mem_ack_out; k++) step();
    check("ack_seen", mem_ack_out, 1);
    pad_en = 0;
    tb_packet_in = '0;
    for (k = 0; k < 20 && mem_ack_out; k++) step();
    check("ack_fall", mem_ack_out, 0);
    if (wr && row < R)
      for (int i = 0; i < TX; i++) if ((col / TX) * TX + i < C) mg[row][(col / TX) * TX + i] = vec[i];
  endtask
  task automatic load();
    logic [31:0] ch;
    for (int r = 0; r < R; r++)
      for (int k = 0; k < 5; k++) begin
        ch = '0;
        for (int i = 0; i < TX; i++) if (k * TX + i < C) ch[i] = g0[r][k * TX + i];
        if (ch != 0) host_req(r, k * TX + int'($urandom_range(0, 31)), ch, 1);
      end
  endtask
  function automatic int nbr(int r, int c);
    int n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < R && c + dc >= 0 && c + dc < C)
          n += int'(mg[r+dr][c+dc]);
    return n;
  endfunction
  function automatic int model_run();
    int total = 0;
    bit chg = 1;
    bit [C-1:0] nx [R];
    while (chg) begin
      chg = 0;
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) nx[r][c] = mg[r][c] && nbr(r, c) >= 4;
      for (int r = 0; r < R; r++) begin
        if (nx[r] != mg[r]) chg = 1;
        total += $countones(mg[r]) - $countones(nx[r]);
        mg[r] = nx[r];
      end
    end
    return total;
  endfunction
  task automatic run_check(input string tag, input int bound, input bit poke);
    int exp = model_run();
    int k;
    run_in = 1;
    step();
    run_in = 0;
    check({tag, "_done_clr"}, done_out, 0);
    check({tag, "_upd_clr"}, updates_out, 0);
    for (k = 0; k < bound && !done_out; k++) begin
      step();
      if (poke && k == 50) begin
        run_in = 1;
        pad_en = 1;
        tb_packet_in = {8'd3, 9'd0, 32'hFFFF_FFFF, 3'b100};
      end
      if (poke && k == 53) begin
        check("run_ack_blocked", mem_ack_out, 0);
        check("run_busy_blocked", mem_busy_out, 0);
        check("run_not_done", done_out, 0);
        run_in = 0;
        pad_en = 0;
        tb_packet_in = '0;
      end
    end
    check({tag, "_done"}, done_out, 1);
    check({tag, "_updates"}, updates_out, exp);
    check_grid({tag, "_grid"});
  endtask
  task automatic clear_g0();
    for (int r = 0; r < R; r++) g0[r] = '0;
  endtask
  initial begin
    do_reset();
    check("rst_done", done_out, 0);
    check("rst_updates", updates_out, 0);
    check("rst_ack", mem_ack_out, 0);
    check("rst_busy", mem_busy_out, 0);
    check_grid("rst_grid");
    tb_packet_in = {8'd2, 9'd0, 32'h0000_000F, 3'b100};
    pad_en = 1;
    step();
    check("wr_busy_c0", mem_busy_out, 1);
    check("wr_ack_c0", mem_ack_out, 0);
    step();
    check("wr_busy_c1", mem_busy_out, 1);
    check("wr_ack_c1", mem_ack_out, 1);
    pad_en = 0;
    tb_packet_in = '0;
    step();
    check("wr_busy_c2", mem_busy_out, 0);
    check("wr_ack_c2", mem_ack_out, 0);
    mg[2] = 140'hF;
    check("wr_row2", dut.main_mem.data.mem[2], 140'hF);
    host_req(5, 37, $urandom, 1);
    host_req(5, 128, 32'hFFFF_FFFF, 1);
    host_req(200, 0, 32'hFFFF_FFFF, 1);
    host_req(7, 0, 32'hFFFF_FFFF, 0);
    check_grid("addr_rules_grid");
    do_reset();
    run_check("empty", 5000, 0);
`ifdef AOC4_PASS_COUNT_EN
    check("empty_passes", passes_out, 1);
`endif
    run_check("empty_again", 5000, 0);
    do_reset();
    clear_g0();
    for (int r = 0; r < 3; r++) g0[r] = 140'h7;
    load();
    run_check("block3", 10000, 0);
    check("block3_nine", updates_out, 9);
    do_reset();
    clear_g0();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) g0[r][c] = sample[r][c] == "@";
    load();
    run_check("sample", 20000, 0);
    for (int t = 0; t < 3; t++) begin
      int r0 = t == 0 ? R - 20 : int'($urandom_range(0, R - 20));
      int c0 = t == 0 ? C - 40 : int'($urandom_range(0, C - 40));
      do_reset();
      clear_g0();
      for (int r = 0; r < 20; r++)
        for (int c = 0; c < 40; c++) g0[r0+r][c0+c] = $urandom_range(0, 99) < 70;
      load();
      run_check("patch", 30000, 0);
    end
    do_reset();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) g0[r][c] = $urandom_range(0, 99) < 65;
    load();
    run_check("full", 60000, 1);
    run_in = 1;
    step();
    run_in = 0;
    repeat (5) step();
    reset = 1;
    #1;
    for (int r = 0; r < R; r++) mg[r] = '0;
    check("abort_done", done_out, 0);
    check("abort_busy", mem_busy_out, 0);
    check_grid("abort_grid");
    step();
    reset = 0;
    step();
    host_req(1, 0, 32'h5, 1);
    check_grid("post_abort_grid");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
